fp_mul_seq: RTL

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fp_mul_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_seq.sv
// fp_mul_seq -- sequential floating-point multiplier for a small
// {sign, exponent, fraction} format with hidden leading one.
//
// An accepted start captures x and y, a shift-add multiply of the two
// significands runs for MW+1 cycles, then a single normalize/round/range
// cycle registers the product. done pulses for one cycle in the DONE state,
// where a new start may be accepted back-to-back.
//
// Optional feature macro: FPM_ROUND_NEAREST_EN
//   defined   -> round to nearest-even using guard/sticky
//   undefined -> truncate
// Latency is identical in both builds.
//
// Parameters:
//   EW - exponent field width (>= 3)
//   MW - fraction field width (>= 2)
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - synchronous active-low reset
//   start - multiply request, accepted in IDLE or DONE only
//   x, y  - operands {sign, exponent, fraction}
//   busy  - high in MUL and NORM
//   done  - one-cycle result-valid pulse
//   z     - product, held until the next NORM
//   of    - overflow flag
//   uf    - underflow flag
module fp_mul_seq #(
    parameter int EW = 4,
    parameter int MW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [EW+MW:0]   x,
    input  logic [EW+MW:0]   y,
    output logic             busy,
    output logic             done,
    output logic [EW+MW:0]   z,
    output logic             of,
    output logic             uf
);

    localparam int W    = 1 + EW + MW;
    localparam int PW   = 2 * MW + 2;
    localparam int XW   = EW + 2;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int CW   = $clog2(MW + 1);

    localparam logic [CW-1:0]        CNT_LAST = CW'(MW);
    localparam logic signed [XW-1:0] E_OVF    = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] E_ZERO   = '0;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic          accept;

    // Operand capture and shift-add working registers (no reset: data only).
    logic          sign_p0;
    logic          zero_p0;
    logic [EW-1:0] ex_p0;
    logic [EW-1:0] ey_p0;
    logic [PW-1:0] mcand_p0;
    logic [MW:0]   mplier_p0;
    logic [PW-1:0] acc_p0;

    // Normalize/round combinational signals.
    logic                 top;
    logic [MW-1:0]        frac;
    logic                 guard;
    logic                 sticky;
    logic [MW:0]          rnd;
    logic signed [XW-1:0] e_raw;
    logic signed [XW-1:0] e_fin;
    logic [W+1:0]         res;

    // Returns {carry, fraction}; a carry means the fraction wrapped to zero.
    function automatic logic [MW:0] round_frac(input logic [MW-1:0] f,
                                               input logic          g,
                                               input logic          s);
`ifdef FPM_ROUND_NEAREST_EN
        return {1'b0, f} + (MW+1)'(g & (s | f[0]));
`else
        logic unused_gs;
        unused_gs = g | s;
        return {1'b0, f};
`endif
    endfunction

    // Range check and packing; returns {of, uf, z}.
    function automatic logic [W+1:0] pack_result(input logic                 s,
                                                 input logic                 zero,
                                                 input logic signed [XW-1:0] e,
                                                 input logic [MW-1:0]        f);
        if (zero)
            return {2'b00, s, {(W-1){1'b0}}};
        else if (e >= E_OVF)
            return {2'b10, s, {EW{1'b1}}, {MW{1'b0}}};
        else if (e <= E_ZERO)
            return {2'b01, s, {(W-1){1'b0}}};
        else
            return {2'b00, s, e[EW-1:0], f};
    endfunction

    assign accept = rst_n && start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == MUL) || (state == NORM);
    assign done   = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = MUL;
            MUL:  if (cnt == CNT_LAST) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: state_nxt = accept ? MUL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= '0;
            else if (state == MUL)
                cnt <= cnt + 1'b1;
        end
    end

    // Stage p0: capture operands, then accumulate one multiplier bit per cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_p0   <= x[W-1] ^ y[W-1];
            ex_p0     <= x[W-2:MW];
            ey_p0     <= y[W-2:MW];
            zero_p0   <= (x[W-2:MW] == '0) || (y[W-2:MW] == '0);
            mcand_p0  <= PW'({1'b1, x[MW-1:0]});
            mplier_p0 <= {1'b1, y[MW-1:0]};
            acc_p0    <= '0;
        end else if (state == MUL) begin
            if (mplier_p0[0])
                acc_p0 <= acc_p0 + mcand_p0;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
        end
    end

    // Stage p1: normalize, round and range-check the finished product.
    always_comb begin
        top = acc_p0[PW-1];
        if (top) begin
            frac   = acc_p0[PW-2:MW+1];
            guard  = acc_p0[MW];
            sticky = |acc_p0[MW-1:0];
        end else begin
            frac   = acc_p0[PW-3:MW];
            guard  = acc_p0[MW-1];
            sticky = |acc_p0[MW-2:0];
        end
        e_raw = XW'(ex_p0) + XW'(ey_p0) - XW'(BIAS) + XW'(top);
        rnd   = round_frac(frac, guard, sticky);
        // A rounding carry leaves rnd[MW-1:0] at zero and bumps the exponent.
        e_fin = e_raw + XW'(rnd[MW]);
        res   = pack_result(sign_p0, zero_p0, e_fin, rnd[MW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z  <= '0;
            of <= 1'b0;
            uf <= 1'b0;
        end else if (state == NORM) begin
            of <= res[W+1];
            uf <= res[W];
            z  <= res[W-1:0];
        end
    end

endmodule
